console_arbiter: RTL and testbench

Sequences and shares the simulation console output CSR (address 0x0FF) between several character producers. Accepts characters and a single exit/fail command over valid/ready handshakes, selects among producers round-robin, and issues one framed CSR write per character with a programmable idle gap between writes. Sits between bench-side or on-chip producers and the console CSR port.

---
 rtl/console_pkg.sv | 37 +++
 rtl/console_arbiter_rr_arbiter.sv | 46 ++++
 rtl/console_arbiter.sv | 126 ++++++++++++
 tb/tb_console_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/console_pkg.sv
// Shared constants, state encoding and CSR word builders for the console arbiter.
package console_pkg;

  localparam logic [11:0] CSR_ADDR  = 12'h0FF;
  localparam int          START_BIT = 11;
  localparam int          CHAR_MSB  = 10;
  localparam int          CHAR_LSB  = 3;
  localparam int          STOP_BIT  = 2;
  localparam int          EXIT_BIT  = 1;
  localparam int          FAIL_BIT  = 0;
  localparam logic [63:0] IDLE_WORD = 64'h4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_GAP,
    ST_HALT
  } state_t;

  function automatic logic [63:0] char_word(input logic [7:0] ch);
    logic [63:0] w;
    w = '0;
    w[START_BIT] = 1'b1;
    w[CHAR_MSB:CHAR_LSB] = ch;
    return w;
  endfunction

  function automatic logic [63:0] exit_word(input logic fail);
    logic [63:0] w;
    w = '0;
    w[STOP_BIT] = 1'b1;
    w[EXIT_BIT] = 1'b1;
    w[FAIL_BIT] = fail;
    return w;
  endfunction

endpackage

// File: rtl/console_arbiter_rr_arbiter.sv
// Round-robin grant: first requester above the last winner, wrapping to index 0.
module rr_arbiter #(
  parameter int N_REQ = 2,
  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic [N_REQ-1:0] req,
  input  logic             update,
  output logic [N_REQ-1:0] grant
);

  logic [IW-1:0] last_reg;
  logic [IW-1:0] hit_idx;
  logic          found;

  // Upper pass covers indices above the last winner, lower pass supplies the wrap.
  always_comb begin
    grant   = '0;
    hit_idx = '0;
    found   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[k] && (k > int'(last_reg))) begin
        found    = 1'b1;
        hit_idx  = IW'(k);
        grant[k] = 1'b1;
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && req[k]) begin
        found    = 1'b1;
        hit_idx  = IW'(k);
        grant[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      last_reg <= IW'(N_REQ - 1);
    end else if (update && found) begin
      last_reg <= hit_idx;
    end
  end

endmodule

// File: rtl/console_arbiter.sv
// Shares the console CSR between character producers and issues one framed
// write per character or exit command, followed by a fixed idle gap.
module console_arbiter
  import console_pkg::*;
#(
  parameter int          N_REQ    = 2,
  parameter int          GAP      = 3,
  parameter logic [11:0] CSR_ADDR = console_pkg::CSR_ADDR
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [N_REQ-1:0]   req_valid_i,
  input  logic [8*N_REQ-1:0] req_char_i,
  output logic [N_REQ-1:0]   req_ready_o,
  input  logic               exit_valid_i,
  input  logic               exit_fail_i,
  output logic               exit_ready_o,
  output logic [11:0]        cadr_o,
  output logic [63:0]        cdat_o,
  output logic               cwe_o,
  output logic               coe_o,
  input  logic               cvalid_i,
  output logic               busy_o,
  output logic               halted_o,
  output logic               err_o
);

  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  state_t             state_reg;
  logic               cwe_reg;
  logic [63:0]        cdat_reg;
  logic               is_exit_reg;
  logic [3:0]         gap_cnt_reg;
  logic               err_reg;
  logic [N_REQ-1:0]   grant;
  logic [7:0]         sel_char;
  logic               in_idle;
  logic               char_fire;
  logic               exit_fire;

  assign in_idle   = (state_reg == ST_IDLE);
  assign char_fire = in_idle && (|req_valid_i);
  assign exit_fire = in_idle && !(|req_valid_i) && exit_valid_i;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .req      (req_valid_i),
    .update   (char_fire),
    .grant    (grant)
  );

  always_comb begin
    sel_char = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant[k]) sel_char = req_char_i[8*k +: 8];
    end
  end

  // Readies are forced low while reset is asserted, even though state already reads IDLE.
  assign req_ready_o  = (in_idle && reset_ni) ? grant : '0;
  assign exit_ready_o = exit_fire && reset_ni;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_reg   <= ST_IDLE;
      cwe_reg     <= 1'b0;
      cdat_reg    <= IDLE_WORD;
      is_exit_reg <= 1'b0;
      gap_cnt_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (char_fire) begin
            cwe_reg     <= 1'b1;
            cdat_reg    <= char_word(sel_char);
            is_exit_reg <= 1'b0;
            state_reg   <= ST_WRITE;
          end else if (exit_fire) begin
            cwe_reg     <= 1'b1;
            cdat_reg    <= exit_word(exit_fail_i);
            is_exit_reg <= 1'b1;
            state_reg   <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          cwe_reg  <= 1'b0;
          cdat_reg <= IDLE_WORD;
          if (!cvalid_i) err_reg <= 1'b1;
          if (is_exit_reg) begin
            state_reg <= ST_HALT;
          end else if (GAP > 0) begin
            state_reg   <= ST_GAP;
            gap_cnt_reg <= GAP_LOAD;
          end else begin
            state_reg <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt_reg == 4'd0) begin
            state_reg <= ST_IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg - 4'd1;
          end
        end
        ST_HALT: begin
          state_reg <= ST_HALT;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign cadr_o   = CSR_ADDR;
  assign cdat_o   = cdat_reg;
  assign cwe_o    = cwe_reg;
  assign coe_o    = 1'b0;
  assign busy_o   = !in_idle;
  assign halted_o = (state_reg == ST_HALT);
  assign err_o    = err_reg;

endmodule

// File: tb/tb_console_arbiter.sv
// Directed checks of console_arbiter: framing, round-robin, gap timing, error, reset abort, exit/halt.
module tb_console_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [15:0] req_char;
  logic [1:0]  req_ready;
  logic        exit_valid;
  logic        exit_fail;
  logic        exit_ready;
  logic [11:0] cadr;
  logic [63:0] cdat;
  logic        cwe;
  logic        coe;
  logic        cvalid;
  logic        busy;
  logic        halted;
  logic        err;

  logic [1:0]  g0_valid;
  logic [15:0] g0_char;
  logic [1:0]  g0_ready;
  logic        g0_exit_ready;
  logic [11:0] g0_cadr;
  logic [63:0] g0_cdat;
  logic        g0_cwe;
  logic        g0_coe;
  logic        g0_busy;
  logic        g0_halted;
  logic        g0_err;

  int n_cmp = 0;
  int n_err = 0;

  console_arbiter #(.N_REQ(2), .GAP(3)) dut (
    .clk_i        (clk),
    .reset_ni     (rst_n),
    .req_valid_i  (req_valid),
    .req_char_i   (req_char),
    .req_ready_o  (req_ready),
    .exit_valid_i (exit_valid),
    .exit_fail_i  (exit_fail),
    .exit_ready_o (exit_ready),
    .cadr_o       (cadr),
    .cdat_o       (cdat),
    .cwe_o        (cwe),
    .coe_o        (coe),
    .cvalid_i     (cvalid),
    .busy_o       (busy),
    .halted_o     (halted),
    .err_o        (err)
  );

  console_arbiter #(.N_REQ(2), .GAP(0)) dut0 (
    .clk_i        (clk),
    .reset_ni     (rst_n),
    .req_valid_i  (g0_valid),
    .req_char_i   (g0_char),
    .req_ready_o  (g0_ready),
    .exit_valid_i (1'b0),
    .exit_fail_i  (1'b0),
    .exit_ready_o (g0_exit_ready),
    .cadr_o       (g0_cadr),
    .cdat_o       (g0_cdat),
    .cwe_o        (g0_cwe),
    .coe_o        (g0_coe),
    .cvalid_i     (1'b1),
    .busy_o       (g0_busy),
    .halted_o     (g0_halted),
    .err_o        (g0_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 30) begin
      @(negedge clk);
      t++;
    end
    expect_eq("wait_idle", 64'(busy), 64'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] t2_exp [4];
    int          k;
    int          extra;
    int          t;
    logic [2:0]  acc;

    t2_exp = '{64'hB08, 64'hB10, 64'hB08, 64'hB10};

    rst_n = 1'b0; req_valid = '0; req_char = '0; exit_valid = 1'b0; exit_fail = 1'b0;
    cvalid = 1'b1; g0_valid = '0; g0_char = '0;
    repeat (2) @(negedge clk);

    // Reset state, with a requester already valid
    req_valid = 2'b01;
    #1;
    expect_eq("rst_ready", 64'(req_ready), 64'd0);
    expect_eq("rst_cwe", 64'(cwe), 64'd0);
    expect_eq("rst_cdat", cdat, 64'h4);
    expect_eq("rst_busy", 64'(busy), 64'd0);
    expect_eq("rst_halted", 64'(halted), 64'd0);
    expect_eq("rst_err", 64'(err), 64'd0);
    expect_eq("rst_exit_ready", 64'(exit_ready), 64'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single 'A' from requester 0, gap timing
    req_char[7:0] = 8'h41;
    req_valid = 2'b01;
    #1;
    expect_eq("t1_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    expect_eq("t1_cwe", 64'(cwe), 64'd1);
    expect_eq("t1_cdat", cdat, 64'hA08);
    expect_eq("t1_cadr", 64'(cadr), 64'h0FF);
    expect_eq("t1_coe", 64'(coe), 64'd0);
    expect_eq("t1_busy", 64'(busy), 64'd1);
    k = 1;
    extra = 0;
    while (req_ready == 2'b00 && k < 20) begin
      @(negedge clk);
      k++;
      if (cwe) extra++;
    end
    expect_eq("t1_next_ready_cycles", 64'(k), 64'd5);
    expect_eq("t1_single_pulse", 64'(extra), 64'd0);
    req_valid = '0;
    @(negedge clk);
    expect_eq("t1_idle_cdat", cdat, 64'h4);

    // Round-robin alternation after reset
    pulse_reset();
    req_char = {8'h62, 8'h61};
    req_valid = 2'b11;
    for (int w = 0; w < 4; w++) begin
      t = 0;
      @(negedge clk);
      while (!cwe && t < 20) begin
        @(negedge clk);
        t++;
      end
      expect_eq($sformatf("t2_word%0d", w), cdat, t2_exp[w]);
    end
    req_valid = '0;
    wait_idle();

    // Write with cvalid low sets sticky error
    expect_eq("t3_err_before", 64'(err), 64'd0);
    cvalid = 1'b0;
    req_char[7:0] = 8'h5A;
    req_valid = 2'b01;
    @(negedge clk);
    expect_eq("t3_cdat", cdat, 64'hAD0);
    expect_eq("t3_err_during", 64'(err), 64'd0);
    req_valid = '0;
    @(negedge clk);
    expect_eq("t3_err_set", 64'(err), 64'd1);
    cvalid = 1'b1;
    wait_idle();
    req_char[15:8] = 8'h31;
    req_valid = 2'b10;
    @(negedge clk);
    expect_eq("t3_cdat2", cdat, 64'h988);
    req_valid = '0;
    @(negedge clk);
    expect_eq("t3_err_sticky", 64'(err), 64'd1);
    wait_idle();

    // Reset in the middle of a write
    req_char[7:0] = 8'h51;
    req_valid = 2'b01;
    @(negedge clk);
    expect_eq("t4_cwe_before", 64'(cwe), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    expect_eq("t4_cwe_abort", 64'(cwe), 64'd0);
    expect_eq("t4_cdat_abort", cdat, 64'h4);
    expect_eq("t4_err_cleared", 64'(err), 64'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    req_char[15:8] = 8'h72;
    req_valid = 2'b10;
    #1;
    expect_eq("t4_ready", 64'(req_ready), 64'd2);
    @(negedge clk);
    expect_eq("t4_cdat", cdat, 64'hB90);
    req_valid = '0;
    extra = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cwe) extra++;
    end
    expect_eq("t4_no_retry", 64'(extra), 64'd0);

    // Char and exit together: char first, then exit with fail, then halt
    pulse_reset();
    req_char[7:0] = 8'h41;
    req_valid = 2'b01;
    exit_valid = 1'b1;
    exit_fail = 1'b1;
    #1;
    expect_eq("t5_char_ready", 64'(req_ready), 64'd1);
    expect_eq("t5_exit_blocked", 64'(exit_ready), 64'd0);
    @(negedge clk);
    expect_eq("t5_char_cdat", cdat, 64'hA08);
    req_valid = '0;
    t = 0;
    while (!exit_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    expect_eq("t5_exit_ready", 64'(exit_ready), 64'd1);
    @(negedge clk);
    expect_eq("t5_exit_cwe", 64'(cwe), 64'd1);
    expect_eq("t5_exit_cdat", cdat, 64'h7);
    exit_valid = 1'b0;
    @(negedge clk);
    expect_eq("t5_halted", 64'(halted), 64'd1);
    expect_eq("t5_halt_cdat", cdat, 64'h4);
    req_valid = 2'b11;
    exit_valid = 1'b1;
    acc = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      acc = acc | {|req_ready, exit_ready, cwe};
    end
    expect_eq("t5_halt_quiet", 64'(acc), 64'd0);
    expect_eq("t5_halt_busy", 64'(busy), 64'd1);
    req_valid = '0;
    exit_valid = 1'b0;

    // GAP=0 instance: one write every other cycle
    pulse_reset();
    g0_char[7:0] = 8'h67;
    g0_valid = 2'b01;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      expect_eq($sformatf("t6_cwe%0d", i), 64'(g0_cwe), 64'((i % 2) == 0));
      if (i == 2) expect_eq("t6_cdat", g0_cdat, 64'hB38);
    end
    g0_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
